// File: rtl/serial_eq_cmp.sv
// Branch-condition comparator: checks a == b two bits per cycle and produces the BEQ/BNE decision.
// Latency: done at edge N after accept (edge m+1 on an early-exit mismatch in slice m); one-cycle done pulse.
// Backpressure: none; start is accepted only in IDLE or DONE and is dropped while busy.
module serial_eq_cmp #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_ne,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             taken
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_l, b_l;
    logic             op_ne_l;
    logic [CW-1:0]    cnt;
    logic             mis;
    logic [WIDTH-1:0] diff;
    logic             slice_mis;
    logic             last;
    logic             accept;
    logic             finish;

    // Select the current 2-bit slice of the shadowed operands' difference.
    always_comb begin
        diff      = a_l ^ b_l;
        slice_mis = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                slice_mis = |diff[2*i +: 2];
            end
        end
        last = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last || (EARLY_EXIT && slice_mis)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back start goes straight to RUN with no idle bubble.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_l     <= '0;
            b_l     <= '0;
            op_ne_l <= 1'b0;
            cnt     <= '0;
            mis     <= 1'b0;
            eq      <= 1'b0;
            taken   <= 1'b0;
        end else begin
            if (accept) begin
                a_l     <= a;
                b_l     <= b;
                op_ne_l <= op_ne;
                cnt     <= '0;
                mis     <= 1'b0;
            end else if (state == RUN) begin
                mis <= mis | slice_mis;
                if (!last) begin
                    cnt <= cnt + CW'(1);
                end
            end
            // Result includes the slice compared on the exit edge.
            if (finish) begin
                eq    <= ~(mis | slice_mis);
                taken <= ~(mis | slice_mis) ^ op_ne_l;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
